// File: rtl/bht_update_ctrl.sv
// Update-side controller for the fetch branch history table: queues retired
// branch outcomes and applies them as read-modify-writes in idle RAM-port cycles.
module bht_update_ctrl #(
    parameter int DATAWIDTH = 2,
    parameter int LOGINDEX  = 8,
    parameter int QDEPTH    = 4,
    parameter int LOGQ      = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 upd_valid_in,
    output logic                 upd_ready_out,
    input  logic [LOGINDEX-1:0]  upd_index_in,
    input  logic                 upd_taken_in,
    input  logic                 lkp_valid_in,
    input  logic [LOGINDEX-1:0]  lkp_index_in,
    output logic                 lkp_pred_out,
    output logic                 ram_we_out,
    output logic [LOGINDEX-1:0]  ram_index_out,
    output logic [DATAWIDTH-1:0] ram_wdata_out,
    input  logic [DATAWIDTH-1:0] ram_rdata_in,
    output logic                 busy_out
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

    state_t               state_q, state_d;
    logic [LOGINDEX-1:0]  fifo_idx_q [QDEPTH];
    logic [QDEPTH-1:0]    fifo_tkn_q;
    logic [LOGQ-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LOGQ:0]        count_q, count_d;
    logic [DATAWIDTH-1:0] ctr_q, ctr_d;

    logic                 push, pop, fifo_empty;
    logic [LOGINDEX-1:0]  head_idx;
    logic                 head_tkn;

    function automatic logic [DATAWIDTH-1:0] sat_step(input logic [DATAWIDTH-1:0] c,
                                                      input logic up);
        if (up) return (c == '1) ? c : c + 1'b1;
        else    return (c == '0) ? c : c - 1'b1;
    endfunction

    always_comb begin
        fifo_empty    = (count_q == '0);
        upd_ready_out = (count_q != (LOGQ+1)'(QDEPTH));
        push          = upd_valid_in && upd_ready_out;
        pop           = (state_q == S_WRITE) && !lkp_valid_in;
        count_d       = count_q + (LOGQ+1)'(push) - (LOGQ+1)'(pop);
        head_idx      = fifo_idx_q[rd_ptr_q];
        head_tkn      = fifo_tkn_q[rd_ptr_q];
        busy_out      = !fifo_empty || (state_q != S_IDLE);
    end

    // Lookups own the port outright; an empty queue parks the index at 0.
    always_comb begin
        lkp_pred_out  = lkp_valid_in ? ram_rdata_in[DATAWIDTH-1] : 1'b0;
        ram_we_out    = pop;
        ram_wdata_out = pop ? sat_step(ctr_q, head_tkn) : '0;
        if (lkp_valid_in)    ram_index_out = lkp_index_in;
        else if (fifo_empty) ram_index_out = '0;
        else                 ram_index_out = head_idx;
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        case (state_q)
            S_IDLE:  if (!fifo_empty) state_d = S_READ;
            S_READ:  if (!lkp_valid_in) begin
                         ctr_d   = ram_rdata_in;
                         state_d = S_WRITE;
                     end
            S_WRITE: if (pop) state_d = (count_d != '0) ? S_READ : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ctr_q    <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Queue payload needs no reset: it is only read while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx_q[wr_ptr_q] <= upd_index_in;
            fifo_tkn_q[wr_ptr_q] <= upd_taken_in;
        end
    end

endmodule
